// File: rtl/dcache_wb.sv
`timescale 1ns/1ps
// dcache_wb: write-back, write-allocate N-way set-associative data cache with a
// single blocking miss FSM between the CPU load/store port and the AXI-bridge line port.
module dcache_wb #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      valid,
    input  logic                      op,
    input  logic [31:0]               addr,
    input  logic [3:0]                wstrb,
    input  logic [31:0]               wdata,
    output logic                      addr_ok,
    output logic                      data_ok,
    output logic [31:0]               rdata,
    output logic                      rd_req,
    output logic [2:0]                rd_type,
    output logic [31:0]               rd_addr,
    input  logic                      rd_rdy,
    input  logic                      ret_valid,
    input  logic                      ret_last,
    input  logic [31:0]               ret_data,
    output logic                      wr_req,
    output logic [2:0]                wr_type,
    output logic [31:0]               wr_addr,
    output logic [3:0]                wr_wstrb,
    output logic [32*LINE_WORDS-1:0]  wr_data,
    input  logic                      wr_rdy
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int CNT_W  = WOFF_W + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL_REQ  = 3'd3;
    localparam logic [2:0] S_FILL      = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              reqOp_q;
    logic [TAG_W-1:0]  reqTag_q;
    logic [IDX_W-1:0]  reqIdx_q;
    logic [WOFF_W-1:0] reqWord_q;
    logic [3:0]        reqWstrb_q;
    logic [31:0]       reqWdata_q;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              victimRr_q, victimRr_d;
    logic [CNT_W-1:0]  cnt_q;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [31:0]       data_q  [SETS][WAYS][LINE_WORDS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];

    logic [WAYS-1:0]   hitVec;
    logic              hit;
    logic [WAY_W-1:0]  hitWay;
    logic [WAY_W-1:0]  freeWay;
    logic              hasFree;
    logic [WAY_W-1:0]  curWay;
    logic [31:0]       selWord;
    logic              accept;
    logic              cntFull;
    logic              unusedAddrBits;

    assign unusedAddrBits = &{1'b0, addr[1:0]};

    always_comb begin
        hitVec = '0;
        hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            hitVec[w] = valid_q[reqIdx_q][w] && (tag_q[reqIdx_q][w] == reqTag_q);
            if (hitVec[w]) hitWay = WAY_W'(w);
        end
    end
    assign hit = |hitVec;

    // Descending scan so the lowest-numbered invalid way is the one that sticks.
    always_comb begin
        freeWay = '0;
        hasFree = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[reqIdx_q][w]) begin
                freeWay = WAY_W'(w);
                hasFree = 1'b1;
            end
        end
    end

    assign addr_ok = valid && ((state_q == S_IDLE) || (state_q == S_LOOKUP && hit));
    assign accept  = valid && addr_ok;
    assign cntFull = (cnt_q == CNT_W'(LINE_WORDS));

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        victimRr_d = victimRr_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (hit) begin
                    state_d = accept ? S_LOOKUP : S_IDLE;
                end else begin
                    victim_d   = hasFree ? freeWay : rr_q[reqIdx_q];
                    victimRr_d = !hasFree;
                    state_d    = (valid_q[reqIdx_q][victim_d] && dirty_q[reqIdx_q][victim_d])
                                 ? S_WRITEBACK : S_FILL_REQ;
                end
            end
            S_WRITEBACK: if (wr_rdy) state_d = S_FILL_REQ;
            S_FILL_REQ:  if (rd_rdy) state_d = S_FILL;
            S_FILL:      if (ret_valid && ret_last) state_d = S_RESP;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            victim_q   <= '0;
            victimRr_q <= 1'b0;
            cnt_q      <= '0;
            reqOp_q    <= 1'b0;
            reqTag_q   <= '0;
            reqIdx_q   <= '0;
            reqWord_q  <= '0;
            reqWstrb_q <= '0;
            reqWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            victimRr_q <= victimRr_d;
            if (accept) begin
                reqOp_q    <= op;
                reqTag_q   <= addr[31 -: TAG_W];
                reqIdx_q   <= addr[OFF_W +: IDX_W];
                reqWord_q  <= addr[2 +: WOFF_W];
                reqWstrb_q <= wstrb;
                reqWdata_q <= wdata;
            end
            if (state_q == S_FILL_REQ && rd_rdy) begin
                cnt_q <= '0;
            end else if (state_q == S_FILL && ret_valid && !cntFull) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // rr only advances when the victim came from it, not when an invalid way was free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (state_q == S_LOOKUP && hit && reqOp_q) begin
            dirty_q[reqIdx_q][hitWay] <= 1'b1;
        end else if (state_q == S_RESP) begin
            valid_q[reqIdx_q][victim_q] <= 1'b1;
            dirty_q[reqIdx_q][victim_q] <= reqOp_q;
            if (victimRr_q) rr_q[reqIdx_q] <= rr_q[reqIdx_q] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state_q == S_LOOKUP && hit && reqOp_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (reqWstrb_q[b])
                        data_q[reqIdx_q][hitWay][reqWord_q][8*b +: 8] <= reqWdata_q[8*b +: 8];
                end
            end
            if (state_q == S_FILL && ret_valid && !cntFull)
                data_q[reqIdx_q][victim_q][cnt_q[WOFF_W-1:0]] <= ret_data;
            if (state_q == S_RESP) begin
                tag_q[reqIdx_q][victim_q] <= reqTag_q;
                if (reqOp_q) begin
                    for (int b = 0; b < 4; b++) begin
                        if (reqWstrb_q[b])
                            data_q[reqIdx_q][victim_q][reqWord_q][8*b +: 8] <= reqWdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    assign curWay  = (state_q == S_RESP) ? victim_q : hitWay;
    assign selWord = data_q[reqIdx_q][curWay][reqWord_q];

    assign data_ok  = (state_q == S_LOOKUP && hit) || (state_q == S_RESP);
    assign rdata    = (data_ok && !reqOp_q) ? selWord : 32'h0;
    assign rd_req   = (state_q == S_FILL_REQ);
    assign rd_type  = 3'b100;
    assign rd_addr  = rd_req ? {reqTag_q, reqIdx_q, {OFF_W{1'b0}}} : 32'h0;
    assign wr_req   = (state_q == S_WRITEBACK);
    assign wr_type  = 3'b100;
    assign wr_wstrb = 4'hf;
    assign wr_addr  = wr_req ? {tag_q[reqIdx_q][victim_q], reqIdx_q, {OFF_W{1'b0}}} : 32'h0;

    always_comb begin
        wr_data = '0;
        if (wr_req) begin
            for (int i = 0; i < LINE_WORDS; i++)
                wr_data[32*i +: 32] = data_q[reqIdx_q][victim_q][i];
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
`timescale 1ns/1ps
// tb_dcache_wb: directed bench for dcache_wb (WAYS=2, SETS=256, LINE_WORDS=4) with an
// inline AXI-bridge responder and hand-computed expected values.
module tb_dcache_wb;
    localparam int LW = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         valid = 1'b0;
    logic         op = 1'b0;
    logic [31:0]  addr = '0;
    logic [3:0]   wstrb = '0;
    logic [31:0]  wdata = '0;
    logic         addr_ok, data_ok;
    logic [31:0]  rdata;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy = 1'b0;
    logic         ret_valid = 1'b0;
    logic         ret_last = 1'b0;
    logic [31:0]  ret_data = '0;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0]  fillWords [LW];
    logic [31:0]  respData;
    int           respLat;
    logic         respDone;
    logic         wrSeen, rdSeen, wrBeforeRd;
    logic [31:0]  wrAddrSeen, rdAddrSeen;
    logic [127:0] wrDataSeen;

    logic         strOp   [16];
    logic [31:0]  strAddr [16];
    logic [31:0]  strData [16];
    logic [31:0]  strExp  [16];
    int           strLen;

    dcache_wb #(.WAYS(2), .SETS(256), .LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
        .ret_data(ret_data), .wr_req(wr_req), .wr_type(wr_type),
        .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic setFill(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        fillWords[0] = w0;
        fillWords[1] = w1;
        fillWords[2] = w2;
        fillWords[3] = w3;
    endtask

    // One CPU request plus the bridge side; stopBeats >= 0 abandons the fill after that many beats.
    task automatic applyStimulus(input logic isStore, input logic [31:0] a, input logic [3:0] strb,
                                 input logic [31:0] d, input int stopBeats);
        int beat;
        beat = -1;
        respDone = 1'b0; respLat = 0; respData = '0;
        wrSeen = 1'b0; rdSeen = 1'b0; wrBeforeRd = 1'b0;
        wrAddrSeen = '0; rdAddrSeen = '0; wrDataSeen = '0;
        valid = 1'b1; op = isStore; addr = a; wstrb = strb; wdata = d;
        #1;
        checkOutput("acceptIdle", 128'(addr_ok), 128'(1));
        tick();
        valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
            if (data_ok) begin
                respDone = 1'b1; respData = rdata; respLat = c + 1;
                break;
            end
            if (stopBeats >= 0 && beat == stopBeats) begin
                respDone = 1'b1;
                break;
            end
            if (wr_req) begin
                wrSeen = 1'b1; wrAddrSeen = wr_addr; wrDataSeen = wr_data;
                if (!rdSeen) wrBeforeRd = 1'b1;
                wr_rdy = 1'b1;
            end
            if (rd_req) begin
                rdSeen = 1'b1; rdAddrSeen = rd_addr; rd_rdy = 1'b1; beat = 0;
            end else if (beat >= 0 && beat < LW) begin
                ret_valid = 1'b1; ret_data = fillWords[beat]; ret_last = (beat == LW - 1);
                beat++;
            end
            tick();
        end
        checkOutput("respTimeout", 128'(respDone), 128'(1));
        if (stopBeats < 0) tick();
    endtask

    task automatic runStream();
        for (int i = 0; i <= strLen; i++) begin
            if (i < strLen) begin
                valid = 1'b1; op = strOp[i]; addr = strAddr[i]; wstrb = 4'hf; wdata = strData[i];
            end else begin
                valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                checkOutput("streamDataOk", 128'(data_ok), 128'(1));
                if (!strOp[i-1]) checkOutput("streamRdata", 128'(rdata), 128'(strExp[i-1]));
            end
            if (i < strLen) checkOutput("streamAddrOk", 128'(addr_ok), 128'(1));
            tick();
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_addrOk"},  128'(addr_ok),  128'(0));
        checkOutput({tag, "_dataOk"},  128'(data_ok),  128'(0));
        checkOutput({tag, "_rdata"},   128'(rdata),    128'(0));
        checkOutput({tag, "_rdReq"},   128'(rd_req),   128'(0));
        checkOutput({tag, "_rdAddr"},  128'(rd_addr),  128'(0));
        checkOutput({tag, "_wrReq"},   128'(wr_req),   128'(0));
        checkOutput({tag, "_wrAddr"},  128'(wr_addr),  128'(0));
        checkOutput({tag, "_wrData"},  wr_data,        128'(0));
    endtask

    initial begin
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        #1;
        checkIdleOutputs("reset");
        checkOutput("rdType",  128'(rd_type),  128'(3'b100));
        checkOutput("wrType",  128'(wr_type),  128'(3'b100));
        checkOutput("wrWstrb", 128'(wr_wstrb), 128'(4'hf));
        tick();

        // Cold load of 0x10, then re-load hits.
        setFill(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, -1);
        checkOutput("coldRdAddr", 128'(rdAddrSeen), 128'(32'h0000_0010));
        checkOutput("coldRdata",  128'(respData),   128'(32'hA0));
        checkOutput("coldLat",    128'(respLat),    128'(7));
        checkOutput("coldNoWr",   128'(wrSeen),     128'(0));
        applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, -1);
        checkOutput("reloadRdata", 128'(respData), 128'(32'hA0));
        checkOutput("reloadLat",   128'(respLat),  128'(1));
        checkOutput("reloadNoRd",  128'(rdSeen),   128'(0));
        applyStimulus(1'b0, 32'h0000_001C, 4'h0, 32'h0, -1);
        checkOutput("word3Rdata", 128'(respData), 128'(32'hA3));

        // Store hit with partial strobe over 0xFFFF_FFFF.
        setFill(32'hFFFF_FFFF, 32'hB1, 32'hB2, 32'hB3);
        applyStimulus(1'b0, 32'h0000_0020, 4'h0, 32'h0, -1);
        checkOutput("line2Rdata", 128'(respData), 128'(32'hFFFF_FFFF));
        applyStimulus(1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678, -1);
        checkOutput("storeHitLat", 128'(respLat), 128'(1));
        applyStimulus(1'b0, 32'h0000_0020, 4'h0, 32'h0, -1);
        checkOutput("storeHitMerged", 128'(respData), 128'(32'hFFFF_5678));

        // Third tag into set 2 evicts the dirty first line before the fill.
        setFill(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        applyStimulus(1'b0, 32'h0000_1020, 4'h0, 32'h0, -1);
        checkOutput("secondWayNoWr", 128'(wrSeen), 128'(0));
        checkOutput("secondWayRdata", 128'(respData), 128'(32'hC0));
        setFill(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        applyStimulus(1'b0, 32'h0000_2020, 4'h0, 32'h0, -1);
        checkOutput("evictWrSeen",   128'(wrSeen),     128'(1));
        checkOutput("evictWrAddr",   128'(wrAddrSeen), 128'(32'h0000_0020));
        checkOutput("evictWrData",   wrDataSeen, {32'hB3, 32'hB2, 32'hB1, 32'hFFFF_5678});
        checkOutput("evictWrFirst",  128'(wrBeforeRd), 128'(1));
        checkOutput("evictRdAddr",   128'(rdAddrSeen), 128'(32'h0000_2020));
        checkOutput("evictRdata",    128'(respData),   128'(32'hD0));
        checkOutput("evictLat",      128'(respLat),    128'(8));
        // rr for set 2 has advanced to way 1, so tag 1 goes and tag 2 stays.
        setFill(32'hE0, 32'hE1, 32'hE2, 32'hE3);
        applyStimulus(1'b0, 32'h0000_0020, 4'h0, 32'h0, -1);
        checkOutput("rrRefillNoWr", 128'(wrSeen),   128'(0));
        checkOutput("rrRefillData", 128'(respData), 128'(32'hE0));
        applyStimulus(1'b0, 32'h0000_2020, 4'h0, 32'h0, -1);
        checkOutput("rrKeptLat",  128'(respLat),  128'(1));
        checkOutput("rrKeptData", 128'(respData), 128'(32'hD0));

        // Eight back-to-back load hits.
        strLen = 8;
        for (int i = 0; i < 8; i++) begin
            strOp[i] = 1'b0; strAddr[i] = 32'h10 + 32'(4 * (i % 4)); strData[i] = '0;
            strExp[i] = 32'hA0 + 32'(i % 4);
        end
        runStream();

        // Store followed immediately by a load of the same word.
        strLen = 2;
        strOp[0] = 1'b1; strAddr[0] = 32'h18; strData[0] = 32'hCAFE_F00D; strExp[0] = '0;
        strOp[1] = 1'b0; strAddr[1] = 32'h18; strData[1] = '0;           strExp[1] = 32'hCAFE_F00D;
        runStream();

        // Store miss allocates, merges, and leaves the line dirty.
        setFill(32'h0F00_0000, 32'h1122_3344, 32'h0F00_0002, 32'h0F00_0003);
        applyStimulus(1'b1, 32'h0000_0034, 4'b0100, 32'h00AB_0000, -1);
        checkOutput("storeMissRdAddr", 128'(rdAddrSeen), 128'(32'h0000_0030));
        checkOutput("storeMissLat",    128'(respLat),    128'(7));
        applyStimulus(1'b0, 32'h0000_0034, 4'h0, 32'h0, -1);
        checkOutput("storeMissMerged", 128'(respData), 128'(32'h11AB_3344));
        checkOutput("storeMissHitLat", 128'(respLat),  128'(1));
        setFill(32'h70, 32'h71, 32'h72, 32'h73);
        applyStimulus(1'b0, 32'h0000_1030, 4'h0, 32'h0, -1);
        applyStimulus(1'b0, 32'h0000_2030, 4'h0, 32'h0, -1);
        checkOutput("storeMissDirtyWr", 128'(wrSeen),     128'(1));
        checkOutput("storeMissWrAddr",  128'(wrAddrSeen), 128'(32'h0000_0030));
        checkOutput("storeMissWrData",  wrDataSeen,
                    {32'h0F00_0003, 32'h0F00_0002, 32'h11AB_3344, 32'h0F00_0000});

        // Reset in the middle of a fill.
        setFill(32'h3A, 32'h3B, 32'h3C, 32'h3D);
        applyStimulus(1'b0, 32'h0000_3040, 4'h0, 32'h0, 2);
        resetn = 1'b0;
        tick();
        #1;
        checkIdleOutputs("midReset");
        resetn = 1'b1;
        tick();
        applyStimulus(1'b0, 32'h0000_3040, 4'h0, 32'h0, -1);
        checkOutput("postResetMiss", 128'(rdSeen),   128'(1));
        checkOutput("postResetLat",  128'(respLat),  128'(7));
        checkOutput("postResetData", 128'(respData), 128'(32'h3A));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
